// File: rtl/arbiter_rr2.sv
// Two-requester round-robin arbiter with registered, mutually exclusive grants
// and a bounded hold timer that forces a switch when the other side is waiting.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | no grant outstanding; next request (tie -> !owner) is granted
//  G0    | requester 0 owns the resource, hold_cnt counts its tenure
//  G1    | requester 1 owns the resource, hold_cnt counts its tenure
module arbiter_rr2 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req_0,
    input  logic req_1,
    output logic gnt_0,
    output logic gnt_1,
    output logic preempt,
    output logic owner
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] G0   = 2'd1;
    localparam logic [1:0] G1   = 2'd2;

    localparam bit HOLD_EN = (MAX_HOLD != 0);
    // MAX_HOLD==0 never reaches the compare, so the clamp only keeps the constant legal
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic             owner_nxt;
    logic             preempt_nxt;

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        owner_nxt    = owner;
        preempt_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (req_0 && req_1) begin
                    state_nxt    = owner ? G0 : G1;
                    owner_nxt    = ~owner;
                    hold_cnt_nxt = '0;
                end else if (req_0) begin
                    state_nxt    = G0;
                    owner_nxt    = 1'b0;
                    hold_cnt_nxt = '0;
                end else if (req_1) begin
                    state_nxt    = G1;
                    owner_nxt    = 1'b1;
                    hold_cnt_nxt = '0;
                end
            end

            G0: begin
                if (req_0) begin
                    if (HOLD_EN && (hold_cnt == HOLD_LAST) && req_1) begin
                        state_nxt    = G1;
                        owner_nxt    = 1'b1;
                        hold_cnt_nxt = '0;
                        preempt_nxt  = 1'b1;
                    end else if (hold_cnt != CNT_MAX) begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end else if (req_1) begin
                    state_nxt    = G1;
                    owner_nxt    = 1'b1;
                    hold_cnt_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end

            G1: begin
                if (req_1) begin
                    if (HOLD_EN && (hold_cnt == HOLD_LAST) && req_0) begin
                        state_nxt    = G0;
                        owner_nxt    = 1'b0;
                        hold_cnt_nxt = '0;
                        preempt_nxt  = 1'b1;
                    end else if (hold_cnt != CNT_MAX) begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end else if (req_0) begin
                    state_nxt    = G0;
                    owner_nxt    = 1'b0;
                    hold_cnt_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt    = IDLE;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    // Grants come straight from flops fed by the next-state decode
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            owner    <= 1'b1;
            preempt  <= 1'b0;
            gnt_0    <= 1'b0;
            gnt_1    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            owner    <= owner_nxt;
            preempt  <= preempt_nxt;
            gnt_0    <= (state_nxt == G0);
            gnt_1    <= (state_nxt == G1);
        end
    end

endmodule
